ifir_phase_sequencer: RTL and testbench

//  Sequencer for the 8x IFIR interpolation stage, run from the single clock_up domain.
//  - Generates the phase selects clock_div2/4/8, the sample-load strobe clock_in and neg_en.
//  - Accepts input samples over a valid/ready handshake through a 1-entry buffer.
//  - Drives the stage Data_in and zero-flushes the delay line on stop.

---
 rtl/ifir_phase_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ifir_phase_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifir_phase_sequencer.sv
// ifir_phase_sequencer
//   Phase/load sequencer for the 8x IFIR interpolation stage. Runs from the
//   single clock_up domain and produces the phase selects, the sample-load
//   strobe, the output-update enable and the stage input sample. Input samples
//   arrive over valid/ready through a one-entry buffer; stopping pushes
//   FLUSH_SAMPLES zero samples through the delay line before going idle.
//
//   Build option: define IFIR_SEQ_UNDERRUN_HOLD_EN to repeat the previous
//   sample on underrun instead of stuffing a zero.
module ifir_phase_sequencer #(
    parameter int DW            = 24,
    parameter int RATIO_LOG2    = 3,   // phase counter width; must be 3 (three phase outputs)
    parameter int FLUSH_SAMPLES = 4
) (
    input  logic          clock_up,
    input  logic          rstn,
    input  logic          enable,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] stage_data,
    output logic          clock_in,
    output logic          clock_div2,
    output logic          clock_div4,
    output logic          clock_div8,
    output logic          neg_en,
    output logic          underrun,
    input  logic          underrun_clr,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam int              FCW        = $clog2(FLUSH_SAMPLES + 1);
    localparam logic [FCW-1:0]  FLUSH_LAST = FCW'(FLUSH_SAMPLES - 1);
    localparam logic [RATIO_LOG2-1:0] PH_ONE = RATIO_LOG2'(1);

    logic [1:0]            state_q, state_d;
    logic [RATIO_LOG2-1:0] ph_q, ph_d;
    logic [DW-1:0]         nbuf_q, nbuf_d;
    logic                  nbuf_full_q, nbuf_full_d;
    logic [DW-1:0]         stage_data_q, stage_data_d;
    logic                  din_ready_q, din_ready_d;
    logic                  underrun_q, underrun_d;
    logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;

    logic ph_last;
    logic accept;
    logic phasing;
    logic run_load;

    assign ph_last  = &ph_q;
    assign accept   = din_valid && din_ready_q;
    assign phasing  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    // The ph==7 edge of RUN consumes an accepted sample directly (bypass)
    assign run_load = (state_q == ST_RUN) && ph_last;

    // Next-state, buffer, phase and load computation
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        nbuf_d       = nbuf_q;
        nbuf_full_d  = nbuf_full_q;
        stage_data_d = stage_data_q;
        underrun_d   = underrun_q && !underrun_clr;
        flush_cnt_d  = flush_cnt_q;

        // Ordinary accept fills the buffer; ready is low whenever it is full
        if (accept && !run_load) begin
            nbuf_d      = din;
            nbuf_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (enable) begin
                    state_d = ST_PRIME;
                end
            end

            ST_PRIME: begin
                ph_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;          // buffer contents are kept
                end else if (nbuf_full_q) begin
                    stage_data_d = nbuf_q;
                    nbuf_full_d  = 1'b0;
                    state_d      = ST_RUN;
                end
            end

            ST_RUN: begin
                ph_d = ph_q + PH_ONE;
                if (ph_last) begin
                    if (nbuf_full_q) begin
                        stage_data_d = nbuf_q;
                        nbuf_full_d  = 1'b0;
                    end else if (accept) begin
                        stage_data_d = din;
                    end else begin
                        underrun_d = 1'b1;      // set wins over clear
`ifdef IFIR_SEQ_UNDERRUN_HOLD_EN
                        stage_data_d = stage_data_q;
`else
                        stage_data_d = '0;
`endif
                    end
                    // Stop request only takes effect after this load
                    if (!enable) begin
                        state_d     = ST_FLUSH;
                        nbuf_full_d = 1'b0;
                        flush_cnt_d = '0;
                    end
                end
            end

            default: begin // ST_FLUSH
                ph_d = ph_q + PH_ONE;
                if (ph_last) begin
                    stage_data_d = '0;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d     = ST_IDLE;
                        ph_d        = '0;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FCW'(1);
                    end
                end
            end
        endcase

        // Registered ready tracks the next buffer/state so it has no input path
        din_ready_d = !nbuf_full_d && (state_d != ST_FLUSH);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock_up or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            ph_q         <= '0;
            nbuf_q       <= '0;
            nbuf_full_q  <= 1'b0;
            stage_data_q <= '0;
            din_ready_q  <= 1'b0;
            underrun_q   <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            nbuf_q       <= nbuf_d;
            nbuf_full_q  <= nbuf_full_d;
            stage_data_q <= stage_data_d;
            din_ready_q  <= din_ready_d;
            underrun_q   <= underrun_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign din_ready  = din_ready_q;
    assign stage_data = stage_data_q;
    assign clock_in   = phasing && ph_last;
    assign clock_div2 = ph_q[0];
    assign clock_div4 = ph_q[1];
    assign clock_div8 = ph_q[2];
    assign neg_en     = phasing;
    assign underrun   = underrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ifir_phase_sequencer.sv
// tb_ifir_phase_sequencer
//   Directed bench for the IFIR phase sequencer: priming, streaming,
//   underrun/clear, bypass load, stop/flush and asynchronous reset.
module tb_ifir_phase_sequencer;

    logic        clock_up;
    logic        rstn;
    logic        enable;
    logic [23:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [23:0] stage_data;
    logic        clock_in;
    logic        clock_div2;
    logic        clock_div4;
    logic        clock_div8;
    logic        neg_en;
    logic        underrun;
    logic        underrun_clr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int pulses;

`ifdef IFIR_SEQ_UNDERRUN_HOLD_EN
    localparam logic [31:0] UNDERRUN_DATA = 32'd100;
`else
    localparam logic [31:0] UNDERRUN_DATA = 32'd0;
`endif

    ifir_phase_sequencer #(
        .DW(24),
        .RATIO_LOG2(3),
        .FLUSH_SAMPLES(4)
    ) dut (
        .clock_up(clock_up),
        .rstn(rstn),
        .enable(enable),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .stage_data(stage_data),
        .clock_in(clock_in),
        .clock_div2(clock_div2),
        .clock_div4(clock_div4),
        .clock_div8(clock_div8),
        .neg_en(neg_en),
        .underrun(underrun),
        .underrun_clr(underrun_clr),
        .busy(busy)
    );

    initial clock_up = 1'b0;
    always #5 clock_up = ~clock_up;

    task automatic tick();
        @(posedge clock_up);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] phase();
        return 32'({clock_div8, clock_div4, clock_div2});
    endfunction

    initial begin
        rstn = 1'b0; enable = 1'b0; din = '0; din_valid = 1'b0; underrun_clr = 1'b0;

        // Reset: every output low
        #12;
        chk("rst_outs", 32'({din_ready, clock_in, clock_div8, clock_div4, clock_div2,
                             neg_en, underrun, busy}), 32'd0);
        chk("rst_data", 32'(stage_data), 32'd0);
        #10 rstn = 1'b1;
        chk("ready_before_clk", 32'(din_ready), 32'd0);
        tick();
        chk("ready_after_clk", 32'(din_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // 1: prime with 100, stream 200, 300
        enable = 1'b1; din = 24'd100; din_valid = 1'b1;
        tick();
        chk("t1_prime_busy", 32'(busy), 32'd1);
        chk("t1_prime_ready", 32'(din_ready), 32'd0);
        chk("t1_prime_neg_en", 32'(neg_en), 32'd0);
        din = 24'd200;
        tick();
        chk("t1_load100", 32'(stage_data), 32'd100);
        chk("t1_ph0", phase(), 32'd0);
        chk("t1_neg_en", 32'(neg_en), 32'd1);
        chk("t1_clkin0", 32'(clock_in), 32'd0);
        tick();
        din = 24'd300;
        for (int k = 1; k <= 7; k++) begin
            chk("t1a_phase", phase(), 32'(k));
            chk("t1a_clock_in", 32'(clock_in), 32'(k == 7));
            chk("t1a_data", 32'(stage_data), 32'd100);
            tick();
        end
        chk("t1_load200", 32'(stage_data), 32'd200);
        chk("t1_ph0_b", phase(), 32'd0);
        tick();
        din_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk("t1b_phase", phase(), 32'(k));
            chk("t1b_clock_in", 32'(clock_in), 32'(k == 7));
            chk("t1b_data", 32'(stage_data), 32'd200);
            tick();
        end
        chk("t1_load300", 32'(stage_data), 32'd300);
        chk("t1_underrun", 32'(underrun), 32'd0);

        // 2: feed 100 then stall -> underrun, then clear
        din = 24'd100; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        chk("t2_load100", 32'(stage_data), 32'd100);
        chk("t2_no_underrun", 32'(underrun), 32'd0);
        for (int k = 0; k < 8; k++) tick();
        chk("t2_underrun_data", 32'(stage_data), UNDERRUN_DATA);
        chk("t2_underrun_set", 32'(underrun), 32'd1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("t2_underrun_clr", 32'(underrun), 32'd0);

        // 3: bypass load of 555 presented only in the ph==7 cycle
        for (int k = 0; k < 6; k++) tick();
        chk("t3_ph7_clkin", 32'(clock_in), 32'd1);
        chk("t3_ready", 32'(din_ready), 32'd1);
        din = 24'd555; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("t3_bypass", 32'(stage_data), 32'd555);
        chk("t3_underrun", 32'(underrun), 32'd0);
        chk("t3_ph0", phase(), 32'd0);

        // 4: stop at ph3, last load of 777, then flush
        din = 24'd777; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick(); tick();
        chk("t4_ph3", phase(), 32'd3);
        enable = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            chk("t4_run_neg_en", 32'(neg_en), 32'd1);
            chk("t4_run_data", 32'(stage_data), 32'd555);
            tick();
        end
        chk("t4_last_load", 32'(stage_data), 32'd777);
        chk("t4_flush_ready", 32'(din_ready), 32'd0);
        enable = 1'b1;
        pulses = 0;
        for (int c = 0; c < 32; c++) begin
            if (c == 16) enable = 1'b0;
            chk("t4_flush_phase", phase(), 32'(c % 8));
            chk("t4_flush_clkin", 32'(clock_in), 32'((c % 8) == 7));
            chk("t4_flush_data", 32'(stage_data), (c < 8) ? 32'd777 : 32'd0);
            chk("t4_flush_busy", 32'(busy), 32'd1);
            if (clock_in) pulses++;
            tick();
        end
        chk("t4_pulses", 32'(pulses), 32'd4);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_neg_en", 32'(neg_en), 32'd0);
        chk("t4_idle_data", 32'(stage_data), 32'd0);
        chk("t4_idle_phase", phase(), 32'd0);
        chk("t4_idle_ready", 32'(din_ready), 32'd1);

        // 5: asynchronous reset at ph5 in RUN with a buffered sample
        enable = 1'b1; din = 24'd10; din_valid = 1'b1;
        tick();
        din = 24'd20;
        tick();
        chk("t5_load10", 32'(stage_data), 32'd10);
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("t5_ph5", phase(), 32'd5);
        #2 rstn = 1'b0; enable = 1'b0;
        #1;
        chk("t5_rst_outs", 32'({din_ready, clock_in, clock_div8, clock_div4, clock_div2,
                                neg_en, underrun, busy}), 32'd0);
        chk("t5_rst_data", 32'(stage_data), 32'd0);
        #1 rstn = 1'b1;
        chk("t5_ready_before_clk", 32'(din_ready), 32'd0);
        tick();
        chk("t5_ready_after_clk", 32'(din_ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        tick();
        chk("t5_prime_wait_busy", 32'(busy), 32'd1);
        chk("t5_prime_wait_neg_en", 32'(neg_en), 32'd0);
        chk("t5_prime_wait_ready", 32'(din_ready), 32'd1);
        enable = 1'b0;
        tick();
        chk("t5_back_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
